// File: rtl/lpgbt_uplink_capture_if.sv
// lpGBT uplink capture bus: frame input, arm/config and readout port.
// master drives frames/config/reads; slave (the capture block) returns status and read data.
interface lpgbt_uplink_capture_if #(
  parameter int FRAME_W = 234,
  parameter int N_CH    = 2,
  parameter int DEPTH   = 16,
  parameter int CW      = $clog2(DEPTH+1),
  parameter int NW      = (FRAME_W+31)/32,
  parameter int CHW     = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int AW      = $clog2(DEPTH),
  parameter int WW      = (NW > 1) ? $clog2(NW) : 1
);
  logic                    frame_valid_i;
  logic [N_CH*FRAME_W-1:0] frame_i;
  logic [N_CH-1:0]         rdy_i;
  logic [N_CH-1:0]         fec_i;
  logic                    arm_i;
  logic [1:0]              mode_i;
  logic [CHW-1:0]          ch_sel_i;
  logic [CW-1:0]           n_frames_i;
  logic [31:0]             match_val_i;
  logic [31:0]             match_mask_i;
  logic                    busy_o;
  logic                    done_o;
  logic [CW-1:0]           count_o;
  logic [15:0]             fec_cnt_o;
  logic                    rd_en_i;
  logic [AW-1:0]           rd_frame_i;
  logic [WW-1:0]           rd_word_i;
  logic [31:0]             rd_data_o;
  logic                    rd_valid_o;

  modport master (
    output frame_valid_i, frame_i, rdy_i, fec_i,
    output arm_i, mode_i, ch_sel_i, n_frames_i,
    output match_val_i, match_mask_i,
    output rd_en_i, rd_frame_i, rd_word_i,
    input  busy_o, done_o, count_o, fec_cnt_o,
    input  rd_data_o, rd_valid_o
  );

  modport slave (
    input  frame_valid_i, frame_i, rdy_i, fec_i,
    input  arm_i, mode_i, ch_sel_i, n_frames_i,
    input  match_val_i, match_mask_i,
    input  rd_en_i, rd_frame_i, rd_word_i,
    output busy_o, done_o, count_o, fec_cnt_o,
    output rd_data_o, rd_valid_o
  );
endinterface

// File: rtl/lpgbt_uplink_capture.sv
// Multi-channel lpGBT uplink frame capture buffer with triggered RAM record.
// Ports: S_AXI_ACLK, S_AXI_ARESETN (async low), bus (slave: frames, arm/config, status, readout).
module lpgbt_uplink_capture #(
  parameter int FRAME_W = 234,
  parameter int N_CH    = 2,
  parameter int DEPTH   = 16,
  parameter int CW      = $clog2(DEPTH+1),
  parameter int NW      = (FRAME_W+31)/32
) (
  input  logic S_AXI_ACLK,
  input  logic S_AXI_ARESETN,
  lpgbt_uplink_capture_if.slave bus
);
  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int AW  = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE, S_ARMED, S_CAP, S_DONE
  } st_t;

  st_t              st_q;
  logic [CHW-1:0]   ch_q;
  logic [1:0]       mode_q;
  logic [31:0]      val_q;
  logic [31:0]      mask_q;
  logic [CW-1:0]    neff_q;
  logic [CW-1:0]    cnt_q;
  logic [15:0]      fec_q;
  logic             busy_q;
  logic             done_q;
  logic [31:0]      rd_data_q;
  logic             rd_valid_q;

  logic [FRAME_W-1:0] ram [DEPTH];

  logic [FRAME_W-1:0] sel;
  logic               fec_ch;
  logic               rdy_ch;
  logic               live;
  logic               good;
  logic               trig;
  logic               wr;
  logic               fec_hit;
  logic [CW-1:0]      cnt_d;
  logic [CW-1:0]      neff_d;
  logic [CHW-1:0]     ch_d;
  logic [NW*32-1:0]   rd_line;
  logic [31:0]        rd_word;

  always_comb begin
    sel    = bus.frame_i[ch_q*FRAME_W +: FRAME_W];
    fec_ch = bus.fec_i[ch_q];
    rdy_ch = bus.rdy_i[ch_q];
    live   = (st_q == S_ARMED) || (st_q == S_CAP);
    good   = bus.frame_valid_i & rdy_ch & live;
    trig   = 1'b1;
    unique case (1'b1)
      (mode_q == 2'd1): trig = fec_ch;
      (mode_q == 2'd2): trig = ((sel[31:0] ^ val_q) & mask_q) == 32'd0;
      default:          trig = 1'b1;
    endcase
    // In CAPTURE every good frame is stored; in ARMED only the trigger.
    wr      = good & ~bus.arm_i & ((st_q == S_CAP) | trig);
    fec_hit = bus.frame_valid_i & fec_ch & live & (fec_q != 16'hFFFF);
    cnt_d   = cnt_q + 1'b1;
    neff_d  = bus.n_frames_i;
    if (bus.n_frames_i == '0 || bus.n_frames_i > CW'(DEPTH))
      neff_d = CW'(DEPTH);
    ch_d = bus.ch_sel_i;
    if (32'(bus.ch_sel_i) >= N_CH)
      ch_d = '0;
    rd_line = '0;
    rd_line[FRAME_W-1:0] = ram[bus.rd_frame_i];
    rd_word = '0;
    if (32'(bus.rd_word_i) < NW)
      rd_word = rd_line[bus.rd_word_i*32 +: 32];
  end

  // Capture RAM is deliberately left uninitialised; count_o says what is valid.
  always_ff @(posedge S_AXI_ACLK) begin
    if (wr)
      ram[cnt_q[AW-1:0]] <= sel;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      st_q       <= S_IDLE;
      ch_q       <= '0;
      mode_q     <= '0;
      val_q      <= '0;
      mask_q     <= '0;
      neff_q     <= '0;
      cnt_q      <= '0;
      fec_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en_i;
      if (bus.rd_en_i)
        rd_data_q <= rd_word;
      if (bus.arm_i) begin
        st_q   <= S_ARMED;
        ch_q   <= ch_d;
        mode_q <= bus.mode_i;
        val_q  <= bus.match_val_i;
        mask_q <= bus.match_mask_i;
        neff_q <= neff_d;
        cnt_q  <= '0;
        fec_q  <= '0;
        busy_q <= 1'b1;
        done_q <= 1'b0;
      end else begin
        if (fec_hit)
          fec_q <= fec_q + 16'd1;
        if (wr) begin
          cnt_q <= cnt_d;
          if (cnt_d == neff_q) begin
            st_q   <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            st_q <= S_CAP;
          end
        end
      end
    end
  end

  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.count_o    = cnt_q;
  assign bus.fec_cnt_o  = fec_q;
  assign bus.rd_data_o  = rd_data_q;
  assign bus.rd_valid_o = rd_valid_q;
endmodule

// File: tb/tb_lpgbt_uplink_capture.sv
// Testbench for lpgbt_uplink_capture: directed scenarios plus random traffic.
// Outputs are compared every cycle against a transaction-level model.
module tb_lpgbt_uplink_capture;
  localparam int FW  = 234;
  localparam int NCH = 2;
  localparam int D   = 16;
  localparam int NW  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lpgbt_uplink_capture_if #(.FRAME_W(FW), .N_CH(NCH), .DEPTH(D)) bus();

  lpgbt_uplink_capture #(.FRAME_W(FW), .N_CH(NCH), .DEPTH(D)) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: phase 0 idle, 1 waiting for trigger, 2 recording, 3 finished.
  int          m_ph, m_ch, m_mode, m_neff, m_cnt, m_fec;
  logic [31:0] m_val, m_mask;
  logic [FW-1:0] m_mem [D];
  bit          m_known [D];
  bit          e_rv;
  logic [31:0] e_rd;
  bit          e_rd_known;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask

  function automatic logic [31:0] word_of(logic [FW-1:0] f, int w);
    logic [31:0] r;
    for (int b = 0; b < 32; b++) begin
      int idx;
      idx = w*32 + b;
      r[b] = (w < NW && idx < FW) ? f[idx] : 1'b0;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_ch = 0; m_mode = 0; m_neff = 0;
    m_cnt = 0; m_fec = 0; m_val = 0; m_mask = 0;
    e_rv = 0; e_rd = 0; e_rd_known = 1;
  endtask

  task automatic model_clock();
    logic [FW-1:0] f;
    bit busy, g, t;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e_rv = bus.rd_en_i;
    if (bus.rd_en_i) begin
      e_rd = word_of(m_mem[bus.rd_frame_i], int'(bus.rd_word_i));
      e_rd_known = m_known[bus.rd_frame_i] || (bus.rd_word_i == 3'd7);
      if (!m_known[bus.rd_frame_i]) e_rd = 32'd0;
    end
    if (bus.arm_i) begin
      m_ch   = (int'(bus.ch_sel_i) >= NCH) ? 0 : int'(bus.ch_sel_i);
      m_mode = int'(bus.mode_i);
      m_val  = bus.match_val_i;
      m_mask = bus.match_mask_i;
      m_neff = int'(bus.n_frames_i);
      if (m_neff == 0 || m_neff > D) m_neff = D;
      m_cnt = 0; m_fec = 0; m_ph = 1;
      return;
    end
    busy = (m_ph == 1 || m_ph == 2);
    if (!busy) return;
    f = bus.frame_i[m_ch*FW +: FW];
    if (bus.frame_valid_i && bus.fec_i[m_ch] && m_fec < 65535) m_fec++;
    g = bus.frame_valid_i && bus.rdy_i[m_ch];
    case (m_mode)
      1: t = bus.fec_i[m_ch];
      2: t = ((f[31:0] ^ m_val) & m_mask) == 0;
      default: t = 1;
    endcase
    if (g && (m_ph == 2 || t)) begin
      m_mem[m_cnt] = f;
      m_known[m_cnt] = 1;
      m_cnt++;
      m_ph = (m_cnt == m_neff) ? 3 : 2;
    end
  endtask

  task automatic compare_all();
    chk("busy", 32'(bus.busy_o), 32'(m_ph == 1 || m_ph == 2));
    chk("done", 32'(bus.done_o), 32'(m_ph == 3));
    chk("count", 32'(bus.count_o), 32'(m_cnt));
    chk("fec_cnt", 32'(bus.fec_cnt_o), 32'(m_fec));
    chk("rd_valid", 32'(bus.rd_valid_o), 32'(e_rv));
    // Word 7 of an unwritten frame still has its padding bits forced to 0.
    if (e_rd_known && e_rd == 32'd0 && bus.rd_word_i == 3'd7)
      chk("rd_pad", bus.rd_data_o >> 10, 32'd0);
    else if (e_rd_known)
      chk("rd_data", bus.rd_data_o, e_rd);
  endtask

  task automatic step();
    model_clock();
    @(posedge clk);
    #1;
    compare_all();
    bus.arm_i = 0;
    bus.rd_en_i = 0;
    bus.frame_valid_i = 0;
  endtask

  task automatic arm(int ch, int mode, int n, logic [31:0] v, logic [31:0] m);
    bus.arm_i = 1;
    bus.ch_sel_i = ch[0];
    bus.mode_i = mode[1:0];
    bus.n_frames_i = n[4:0];
    bus.match_val_i = v;
    bus.match_mask_i = m;
    step();
  endtask

  task automatic rand_frame();
    for (int i = 0; i < NCH*FW; i++)
      bus.frame_i[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic frame(logic [31:0] low, logic [1:0] rdy, logic [1:0] fec);
    rand_frame();
    for (int c = 0; c < NCH; c++)
      bus.frame_i[c*FW +: 32] = low;
    bus.frame_valid_i = 1;
    bus.rdy_i = rdy;
    bus.fec_i = fec;
    step();
  endtask

  task automatic rd(int f, int w, output logic [31:0] d);
    bus.rd_en_i = 1;
    bus.rd_frame_i = f[3:0];
    bus.rd_word_i = w[2:0];
    step();
    d = bus.rd_data_o;
  endtask

  logic [31:0] d;

  initial begin
    for (int i = 0; i < D; i++) m_known[i] = 0;
    model_reset();
    bus.frame_valid_i = 0; bus.frame_i = '0; bus.rdy_i = 0; bus.fec_i = 0;
    bus.arm_i = 0; bus.mode_i = 0; bus.ch_sel_i = 0; bus.n_frames_i = 0;
    bus.match_val_i = 0; bus.match_mask_i = 0;
    bus.rd_en_i = 0; bus.rd_frame_i = 0; bus.rd_word_i = 0;
    repeat (3) step();
    #2 rst_n = 1;
    step();
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_done", 32'(bus.done_o), 0);
    chk("rst_count", 32'(bus.count_o), 0);
    chk("rst_rdv", 32'(bus.rd_valid_o), 0);

    // Mode 0 on channel 1, four frames.
    arm(1, 0, 4, 0, 0);
    chk("m0_busy", 32'(bus.busy_o), 1);
    chk("m0_cnt0", 32'(bus.count_o), 0);
    for (int k = 0; k < 8; k++) begin
      frame(k, 2'b11, 2'b00);
      if (k == 3) begin
        chk("m0_done", 32'(bus.done_o), 1);
        chk("m0_cnt4", 32'(bus.count_o), 4);
      end
    end
    for (int k = 0; k < 4; k++) begin
      rd(k, 0, d);
      chk("m0_rd", d, k);
    end

    // Mode 2 pattern trigger.
    arm(0, 2, 4, 32'h0000_00AB, 32'h0000_FFFF);
    for (int v = 'hA8; v <= 'hB0; v++)
      frame({16'($urandom), 16'(v)}, 2'b11, 2'b00);
    for (int k = 0; k < 4; k++) begin
      rd(k, 0, d);
      chk("m2_rd", d & 32'hFFFF, 32'h00AB + k);
    end

    // Mode 1 FEC trigger with FEC counting.
    arm(0, 1, 2, 0, 0);
    for (int j = 1; j <= 6; j++)
      frame(j, 2'b11, {1'b0, (j == 3 || j == 5)});
    chk("m1_fec", 32'(bus.fec_cnt_o), 1);
    chk("m1_done", 32'(bus.done_o), 1);
    frame(9, 2'b11, 2'b01);
    chk("m1_fec_hold", 32'(bus.fec_cnt_o), 1);
    rd(0, 0, d); chk("m1_rd0", d, 3);
    rd(1, 0, d); chk("m1_rd1", d, 4);

    // Clamp n=0 to DEPTH with a rdy gap.
    arm(0, 0, 0, 0, 0);
    for (int j = 0; j < 22; j++)
      frame(j, (j >= 5 && j <= 7) ? 2'b10 : 2'b11, 2'b00);
    chk("cl_cnt", 32'(bus.count_o), 16);
    chk("cl_done", 32'(bus.done_o), 1);
    rd(5, 0, d); chk("cl_gap", d, 8);
    rd(15, 0, d); chk("cl_last", d, 18);
    rd(5, 7, d); chk("cl_pad", d >> 10, 0);

    // Re-arm mid-capture, then async reset.
    arm(0, 0, 8, 0, 0);
    frame(1, 2'b11, 2'b00);
    frame(2, 2'b11, 2'b00);
    chk("ra_cnt2", 32'(bus.count_o), 2);
    arm(0, 0, 8, 0, 0);
    chk("ra_cnt0", 32'(bus.count_o), 0);
    chk("ra_busy", 32'(bus.busy_o), 1);
    frame(3, 2'b11, 2'b01);
    rd(0, 0, d);
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("ar_busy", 32'(bus.busy_o), 0);
    chk("ar_cnt", 32'(bus.count_o), 0);
    chk("ar_fec", 32'(bus.fec_cnt_o), 0);
    chk("ar_rd", bus.rd_data_o, 0);
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    #2 rst_n = 1;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        bus.arm_i = 1;
        bus.ch_sel_i = 1'($urandom_range(0, 1));
        bus.mode_i = 2'($urandom_range(0, 3));
        bus.n_frames_i = 5'($urandom_range(0, 31));
        bus.match_val_i = $urandom;
        bus.match_mask_i = 32'($urandom_range(0, 3));
      end
      rand_frame();
      bus.frame_valid_i = 1'($urandom_range(0, 1));
      for (int c = 0; c < NCH; c++)
        bus.rdy_i[c] = ($urandom_range(0, 7) != 0);
      for (int c = 0; c < NCH; c++)
        bus.fec_i[c] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        bus.rd_en_i = 1;
        bus.rd_frame_i = 4'($urandom_range(0, 15));
        bus.rd_word_i = 3'($urandom_range(0, 7));
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
